// File: rtl/keypad_calc_ctrl.sv
// Keyboard calculator sequencer: filters PS/2 prefixes, assembles two decimal
// operands and an operator from LUT-decoded keys, and computes the result on Enter.
module keypad_calc_ctrl #(
  parameter int MAX_DIGITS = 3,
  parameter int OPERAND_W  = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    scan_code_in,
  input  logic                          scan_code_valid,
  output logic [7:0]                    lut_scan_code,
  input  logic [3:0]                    lut_binary,
  output logic [OPERAND_W-1:0]          operand_a,
  output logic [OPERAND_W-1:0]          operand_b,
  output logic [1:0]                    operator_out,
  output logic signed [2*OPERAND_W:0]   result,
  output logic                          result_valid,
  output logic [2:0]                    calc_state,
  output logic                          overrun
);

  localparam int RES_W = 2*OPERAND_W + 1;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_ESC   = 8'h76;
  localparam logic [7:0] CODE_ENTER = 8'h5A;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  typedef enum logic [1:0] {
    S_OPA  = 2'd0,
    S_OPB  = 2'd1,
    S_CALC = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic                    vld_p0;
  logic                    break_pending, break_nxt;
  logic [CNT_W-1:0]        a_cnt, a_cnt_nxt, b_cnt, b_cnt_nxt;
  logic [OPERAND_W-1:0]    a_nxt, b_nxt;
  logic [1:0]              op_nxt, key_op;
  logic signed [RES_W-1:0] res_nxt;
  logic                    rv_nxt, key_digit;

  // Decimal shift-in: acc*10 + d, built from shifts so no multiplier is needed.
  function automatic logic [OPERAND_W-1:0] acc_digit(input logic [OPERAND_W-1:0] acc,
                                                     input logic [3:0] d);
    logic [OPERAND_W+3:0] wide;
    wide = {4'd0, acc};
    return OPERAND_W'((wide << 3) + (wide << 1) + {{OPERAND_W{1'b0}}, d});
  endfunction

  // Operands are unsigned, so zero-extend before the signed operation.
  function automatic logic signed [RES_W-1:0] calc(input logic [OPERAND_W-1:0] a,
                                                   input logic [OPERAND_W-1:0] b,
                                                   input logic [1:0] op);
    logic signed [RES_W-1:0] ea, eb;
    ea = signed'({{(OPERAND_W+1){1'b0}}, a});
    eb = signed'({{(OPERAND_W+1){1'b0}}, b});
    case (op)
      OP_ADD:  return ea + eb;
      OP_SUB:  return ea - eb;
      OP_MUL:  return ea * eb;
      default: return '0;
    endcase
  endfunction

  assign key_digit  = (lut_binary <= 4'd9);
  assign calc_state = {1'b0, state};

  always_comb begin
    key_op = OP_NONE;
    case (lut_binary)
      4'd10:   key_op = OP_SUB;
      4'd11:   key_op = OP_ADD;
      4'd12:   key_op = OP_MUL;
      default: key_op = OP_NONE;
    endcase
  end

  always_comb begin
    state_nxt = state;
    break_nxt = break_pending;
    a_cnt_nxt = a_cnt;
    b_cnt_nxt = b_cnt;
    a_nxt     = operand_a;
    b_nxt     = operand_b;
    op_nxt    = operator_out;
    res_nxt   = result;
    rv_nxt    = 1'b0;
    if (state == S_CALC) begin
      res_nxt   = calc(operand_a, operand_b, operator_out);
      rv_nxt    = 1'b1;
      state_nxt = S_SHOW;
    end else if (vld_p0) begin
      // Raw-code checks come first: Enter shares its LUT value with the error code.
      if (break_pending) begin
        break_nxt = 1'b0;
      end else if (lut_scan_code == CODE_BREAK) begin
        break_nxt = 1'b1;
      end else if (lut_scan_code == CODE_EXT) begin
        break_nxt = 1'b0;
      end else if (lut_scan_code == CODE_ESC) begin
        a_nxt     = '0;
        b_nxt     = '0;
        op_nxt    = OP_NONE;
        res_nxt   = '0;
        a_cnt_nxt = '0;
        b_cnt_nxt = '0;
        state_nxt = S_OPA;
      end else if (lut_scan_code == CODE_ENTER) begin
        if (state == S_OPB && b_cnt != '0) state_nxt = S_CALC;
      end else if (key_digit) begin
        case (state)
          S_OPA: if (a_cnt < CNT_MAX) begin
            a_nxt     = acc_digit(operand_a, lut_binary);
            a_cnt_nxt = a_cnt + CNT_ONE;
          end
          S_OPB: if (b_cnt < CNT_MAX) begin
            b_nxt     = acc_digit(operand_b, lut_binary);
            b_cnt_nxt = b_cnt + CNT_ONE;
          end
          S_SHOW: begin
            a_nxt     = OPERAND_W'(lut_binary);
            a_cnt_nxt = CNT_ONE;
            b_nxt     = '0;
            b_cnt_nxt = '0;
            op_nxt    = OP_NONE;
            res_nxt   = '0;
            state_nxt = S_OPA;
          end
          default: state_nxt = state;
        endcase
      end else if (key_op != OP_NONE) begin
        case (state)
          S_OPA: if (a_cnt != '0) begin
            op_nxt    = key_op;
            state_nxt = S_OPB;
          end
          S_OPB: if (b_cnt == '0) op_nxt = key_op;
          default: state_nxt = state;
        endcase
      end
    end
  end

  // Stage p0: capture the byte for the LUT; the following cycle is the decode slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_scan_code <= '0;
      vld_p0        <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      vld_p0 <= scan_code_valid && !vld_p0;
      if (scan_code_valid && !vld_p0) lut_scan_code <= scan_code_in;
      if (scan_code_valid && vld_p0)  overrun <= 1'b1;
    end
  end

  // Stage p1: architectural update at the end of decode or CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_OPA;
      break_pending <= 1'b0;
      a_cnt         <= '0;
      b_cnt         <= '0;
      operand_a     <= '0;
      operand_b     <= '0;
      operator_out  <= OP_NONE;
      result        <= '0;
      result_valid  <= 1'b0;
    end else begin
      state         <= state_nxt;
      break_pending <= break_nxt;
      a_cnt         <= a_cnt_nxt;
      b_cnt         <= b_cnt_nxt;
      operand_a     <= a_nxt;
      operand_b     <= b_nxt;
      operator_out  <= op_nxt;
      result        <= res_nxt;
      result_valid  <= rv_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_calc_ctrl.sv
// Self-checking bench for keypad_calc_ctrl: key-level reference model compared every
// cycle, directed calculator sequences with literal expectations, then random keys.
module tb_keypad_calc_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [7:0]         scan_code_in = 8'h00;
  logic               scan_code_valid = 1'b0;
  logic [7:0]         lut_scan_code;
  logic [3:0]         lut_binary;
  logic [9:0]         operand_a, operand_b;
  logic [1:0]         operator_out;
  logic signed [20:0] result;
  logic               result_valid;
  logic [2:0]         calc_state;
  logic               overrun;

  int checks = 0;
  int errors = 0;
  int rv_count = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] lut_fn(input logic [7:0] c);
    case (c)
      8'h45: return 4'd0;
      8'h16: return 4'd1;
      8'h1E: return 4'd2;
      8'h26: return 4'd3;
      8'h25: return 4'd4;
      8'h2E: return 4'd5;
      8'h36: return 4'd6;
      8'h3D: return 4'd7;
      8'h3E: return 4'd8;
      8'h46: return 4'd9;
      8'h7B, 8'h4E: return 4'd10;
      8'h79, 8'h55: return 4'd11;
      8'h7C: return 4'd12;
      8'h76: return 4'd13;
      8'h0E: return 4'd15;
      default: return 4'd14;
    endcase
  endfunction

  assign lut_binary = lut_fn(lut_scan_code);

  keypad_calc_ctrl #(.MAX_DIGITS(3), .OPERAND_W(10)) dut (
    .clk(clk), .rst(rst), .scan_code_in(scan_code_in), .scan_code_valid(scan_code_valid),
    .lut_scan_code(lut_scan_code), .lut_binary(lut_binary), .operand_a(operand_a),
    .operand_b(operand_b), .operator_out(operator_out), .result(result),
    .result_valid(result_valid), .calc_state(calc_state), .overrun(overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: operands as plain integers, state as calculator phase number.
  int         m_a = 0, m_b = 0, m_op = 0, m_st = 0, m_acnt = 0, m_bcnt = 0, m_res = 0;
  bit         m_rv = 0, m_ovr = 0, m_brk = 0, m_pend = 0;
  logic [7:0] m_code = 8'h00;

  task automatic model_reset();
    m_a = 0; m_b = 0; m_op = 0; m_st = 0; m_acnt = 0; m_bcnt = 0; m_res = 0;
    m_rv = 0; m_ovr = 0; m_brk = 0; m_pend = 0; m_code = 8'h00;
  endtask

  task automatic apply_key(input logic [7:0] c);
    int d;
    d = int'(lut_fn(c));
    if (m_brk) m_brk = 0;
    else if (c == 8'hF0) m_brk = 1;
    else if (c == 8'hE0) m_brk = 0;
    else if (c == 8'h76) begin
      m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_acnt = 0; m_bcnt = 0; m_st = 0;
    end else if (c == 8'h5A) begin
      if (m_st == 1 && m_bcnt > 0) m_st = 2;
    end else if (d <= 9) begin
      if (m_st == 0 && m_acnt < 3) begin m_a = m_a * 10 + d; m_acnt++; end
      else if (m_st == 1 && m_bcnt < 3) begin m_b = m_b * 10 + d; m_bcnt++; end
      else if (m_st == 3) begin
        m_a = d; m_acnt = 1; m_b = 0; m_bcnt = 0; m_op = 0; m_res = 0; m_st = 0;
      end
    end else if (d >= 10 && d <= 12) begin
      int opv;
      opv = (d == 11) ? 1 : (d == 10) ? 2 : 3;
      if (m_st == 0 && m_acnt > 0) begin m_op = opv; m_st = 1; end
      else if (m_st == 1 && m_bcnt == 0) m_op = opv;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else begin
      m_rv = 0;
      if (m_st == 2) begin
        m_res = (m_op == 1) ? m_a + m_b : (m_op == 2) ? m_a - m_b : m_a * m_b;
        m_rv  = 1;
        m_st  = 3;
      end else if (m_pend) apply_key(m_code);
      if (scan_code_valid) begin
        if (m_pend) m_ovr = 1;
        else m_code = scan_code_in;
      end
      m_pend = scan_code_valid && !m_pend;
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    logic [20:0] e_res;
    @(negedge clk);
    e_res = m_res[20:0];
    if (result_valid) rv_count++;
    chk("lut_scan_code", {24'd0, lut_scan_code}, {24'd0, m_code});
    chk("operand_a", {22'd0, operand_a}, m_a);
    chk("operand_b", {22'd0, operand_b}, m_b);
    chk("operator_out", {30'd0, operator_out}, m_op);
    chk("result", {11'd0, result}, {11'd0, e_res});
    chk("result_valid", {31'd0, result_valid}, {31'd0, m_rv});
    chk("calc_state", {29'd0, calc_state}, m_st);
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [7:0] c, input int gap);
    @(negedge clk);
    scan_code_in = c;
    scan_code_valid = 1'b1;
    @(negedge clk);
    scan_code_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_pair(input logic [7:0] c1, input logic [7:0] c2);
    @(negedge clk);
    scan_code_in = c1;
    scan_code_valid = 1'b1;
    @(negedge clk);
    scan_code_in = c2;
    @(negedge clk);
    scan_code_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [7:0] pick_code();
    logic [7:0] digs [10];
    int r;
    digs = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    r = $urandom_range(0, 99);
    if (r < 45) return digs[$urandom_range(0, 9)];
    else if (r < 52) return 8'h79;
    else if (r < 58) return 8'h7B;
    else if (r < 64) return 8'h7C;
    else if (r < 78) return 8'h5A;
    else if (r < 82) return 8'h76;
    else if (r < 88) return 8'hF0;
    else if (r < 92) return 8'hE0;
    else return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk("reset operand_a", {22'd0, operand_a}, 0);
    chk("reset operand_b", {22'd0, operand_b}, 0);
    chk("reset operator", {30'd0, operator_out}, 0);
    chk("reset result", {11'd0, result}, 0);
    chk("reset state", {29'd0, calc_state}, 0);
    chk("reset overrun", {31'd0, overrun}, 0);
    chk("reset lut_scan_code", {24'd0, lut_scan_code}, 0);
    rst = 1'b0;

    // 123 + 45
    send(8'h16, 0); send(8'h1E, 0); send(8'h26, 0); send(8'h79, 0);
    send(8'h25, 0); send(8'h2E, 0); send(8'h5A, 0);
    settle();
    chk("add operand_a", {22'd0, operand_a}, 123);
    chk("add operand_b", {22'd0, operand_b}, 45);
    chk("add operator", {30'd0, operator_out}, 1);
    chk("add result", {11'd0, result}, 168);
    chk("add state", {29'd0, calc_state}, 3);
    chk("add pulses", rv_count, 1);

    // 7 - 9 with break codes after each make
    send(8'h3D, 0); send(8'hF0, 0); send(8'h3D, 0);
    send(8'h7B, 0); send(8'hF0, 0); send(8'h7B, 0);
    send(8'h46, 0); send(8'hF0, 0); send(8'h46, 0);
    send(8'h5A, 0); send(8'hF0, 0); send(8'h5A, 0);
    settle();
    chk("sub result", {11'd0, result}, 32'h001FFFFE);
    chk("sub operand_a", {22'd0, operand_a}, 7);
    chk("sub pulses", rv_count, 2);

    // 9999 * 999, fourth digit dropped
    send(8'h76, 0);
    repeat (4) send(8'h46, 0);
    settle();
    chk("mul operand_a", {22'd0, operand_a}, 999);
    send(8'h7C, 0);
    repeat (3) send(8'h46, 0);
    send(8'h5A, 0);
    settle();
    chk("mul result", {11'd0, result}, 998001);
    chk("mul operator", {30'd0, operator_out}, 3);

    // Ignored keys, then operator replacement while b is empty
    send(8'h76, 0);
    settle();
    chk("esc result", {11'd0, result}, 0);
    chk("esc state", {29'd0, calc_state}, 0);
    send(8'h5A, 0); send(8'h79, 0);
    settle();
    chk("opa ignore state", {29'd0, calc_state}, 0);
    chk("opa ignore operator", {30'd0, operator_out}, 0);
    send(8'h2E, 0); send(8'h79, 0); send(8'h5A, 0);
    settle();
    chk("opb enter ignored", {29'd0, calc_state}, 1);
    send(8'h7B, 0);
    settle();
    chk("opb replace operator", {30'd0, operator_out}, 2);
    chk("no extra pulse", rv_count, 3);

    // Overrun and Esc
    chk("overrun clear", {31'd0, overrun}, 0);
    send_pair(8'h16, 8'h1E);
    settle();
    chk("overrun operand_b", {22'd0, operand_b}, 1);
    chk("overrun set", {31'd0, overrun}, 1);
    send(8'h76, 0);
    settle();
    chk("esc operand_a", {22'd0, operand_a}, 0);
    chk("esc operand_b", {22'd0, operand_b}, 0);
    chk("overrun sticky", {31'd0, overrun}, 1);

    // Async reset during CALC
    send(8'h16, 0); send(8'h79, 0); send(8'h1E, 0); send(8'h5A, 0);
    @(posedge clk);
    #1;
    chk("in calc", {29'd0, calc_state}, 2);
    rst = 1'b1;
    #1;
    chk("async rst operand_a", {22'd0, operand_a}, 0);
    chk("async rst operand_b", {22'd0, operand_b}, 0);
    chk("async rst state", {29'd0, calc_state}, 0);
    chk("async rst overrun", {31'd0, overrun}, 0);
    chk("async rst result_valid", {31'd0, result_valid}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("no pulse after rst", rv_count, 3);
    send(8'h3D, 0); send(8'h7C, 0); send(8'h26, 0); send(8'h5A, 0);
    settle();
    chk("post rst result", {11'd0, result}, 21);
    chk("post rst pulses", rv_count, 4);

    // Random keys with random spacing, including back-to-back pairs
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) send_pair(pick_code(), pick_code());
      else send(pick_code(), $urandom_range(0, 3));
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_calc_ctrl.md
# keypad_calc_ctrl

Sequencing controller for the keyboard calculator. Takes validated PS/2 scan codes from the keyboard front end and drives the combinational scan-code-to-binary lookup table. It filters break and extended prefixes, then assembles two decimal operands and an operator. On Enter it computes and holds the result for the display path.

## Interface
- `MAX_DIGITS`, default 3: maximum decimal digits per operand.
- `OPERAND_W`, default 10: operand width in bits. Must hold 10^MAX_DIGITS − 1.
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `scan_code_in` in 8: scan code byte. Valid only with `scan_code_valid`.
- `scan_code_valid` in 1: one-cycle pulse per received byte.
- `lut_scan_code` out 8: registered code presented to the LUT.
- `lut_binary` in 4: LUT output, combinational from `lut_scan_code`.
- `operand_a` out OPERAND_W: first operand, unsigned.
- `operand_b` out OPERAND_W: second operand, unsigned.
- `operator_out` out 2: 00 none, 01 add, 10 sub, 11 mul.
- `result` out 2*OPERAND_W+1: signed two's-complement result.
- `result_valid` out 1: one-cycle pulse when `result` updates.
- `calc_state` out 3: current state encoding, for display and debug.
- `overrun` out 1: sticky flag, cleared only by `rst`.

## Operation
- Reset: all outputs 0, state OPA, prefix flags cleared, digit counters 0.
- **Capture.** When `scan_code_valid` is high in a non-DECODE cycle, `scan_code_in` is registered into `lut_scan_code`. The controller then enters DECODE for exactly one cycle and samples `lut_binary` there.
- **Overrun.** A `scan_code_valid` pulse arriving during DECODE is dropped and sets `overrun`.
- **Prefix 8'hF0 (break).** Sets `break_pending`. The next byte is discarded and clears `break_pending`. No state change.
- **Prefix 8'hE0 (extended).** Discarded. The following byte is processed normally, unless a break is pending.
- **Key classes** (decided in DECODE, in priority order):
  1. Raw code 8'h76 (Esc) → clear: operands, operator, result and counters go to 0, state goes to OPA.
  2. Raw code 8'h5A (Enter) → ENTER. Enter is detected from the raw code because LUT value 14 is shared with the error code.
  3. `lut_binary` 0–9 → DIGIT.
  4. `lut_binary` 11 → add, 10 → sub, 12 → mul.
  5. Any other value (13, 14, 15) → ignored.
- **Digit accumulate.** acc ← acc*10 + d, only while the digit count is below MAX_DIGITS. Further digits are ignored. Leading zeros count as digits.
- **States** (`calc_state`: OPA=0, OPB=1, CALC=2, SHOW=3):
  - **OPA.** DIGIT accumulates into `operand_a`. An operator is ignored if the a-count is 0. Otherwise it stores `operator_out` and moves to OPB. ENTER is ignored.
  - **OPB.** DIGIT accumulates into `operand_b`. An operator replaces `operator_out` only while the b-count is 0, and is ignored otherwise. ENTER with b-count 0 is ignored; otherwise the state moves to CALC.
  - **CALC** (one cycle, no key accepted):
    - `result` ← a+b, a−b, or a*b, with operands zero-extended and the result sign-extended to 2*OPERAND_W+1 bits.
    - `result_valid` pulses.
    - Next state is SHOW.
  - **SHOW.** Operands, operator and result are held.
    - DIGIT clears `operand_b`, `operator_out` and `result`, loads `operand_a` with the digit (count 1), and moves to OPA.
    - Operator and ENTER are ignored.
- The DECODE cycle is an internal sub-step and is not visible on `calc_state`. The architectural state is updated at the end of DECODE.

## Timing
- Valid at edge N → `lut_scan_code` updates at N+1 → operand/state update at N+2.
- Enter at edge N → CALC at N+2 → `result` and `result_valid` at N+3. `result_valid` is high for exactly one cycle.
- Back-to-back valids one cycle apart: the second is dropped and `overrun` is set. Valids two or more cycles apart are all accepted.
- Async `rst` mid-operation, including during DECODE or CALC, immediately forces all outputs to their reset values. There is no `result_valid` pulse.
- Width: worst-case mul 999*999 = 998001 fits in 21 bits. Worst-case sub 0−999 = −999.

## Test plan
- Keys 1,2,3,+,4,5,Enter (make codes only) → `operand_a` = 123, `operand_b` = 45, `operator_out` = 01, `result` = 168, a single `result_valid` pulse, state SHOW.
- Keys 7,−,9,Enter with F0-prefixed break codes after each make → breaks ignored, `result` = −2 (21'h1FFFFE).
- Keys 9,9,9,9,*,9,9,9,Enter → fourth digit ignored, `result` = 998001.
- Enter in OPA, operator in OPA with no digits, Enter in OPB with no digits → all ignored, outputs unchanged. Then +,− with b empty → `operator_out` = 10.
- Two valids one cycle apart → first processed, second dropped, `overrun` = 1 until `rst`. Esc (8'h76) mid-entry → everything zero, state OPA.
- Assert `rst` during CALC → outputs 0 asynchronously, no `result_valid`. The next sequence works normally.
